// File: rtl/dcdr_scan_ctrl.sv
// Channel-scan sequencer for the 3-to-8 / 2-to-4 decoder stage: walks the set bits of a
// latched channel mask, holding each channel for a programmable dwell, single-pass or looping.
module dcdr_scan_ctrl #(
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [7:0]         mask,
    input  logic [DWELL_W-1:0] dwell,
    input  logic               loop_mode,
    output logic               x,
    output logic               y,
    output logic               z,
    output logic               en,
    output logic               busy,
    output logic               done
);

    typedef enum logic {IDLE = 1'b0, ACTIVE = 1'b1} state_t;

    state_t             state;
    logic [2:0]         ch;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] reload;
    logic [7:0]         mask_q;
    logic               loop_q;

    // Lowest set bit of m; only meaningful when m is non-zero.
    function automatic logic [2:0] lowest_bit(input logic [7:0] m);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = i[2:0];
        end
        return idx;
    endfunction

    // {found, index} of the lowest set bit strictly above channel c.
    function automatic logic [3:0] next_bit(input logic [7:0] m, input logic [2:0] c);
        logic [3:0] res;
        res = 4'd0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i] && (i > int'(c))) res = {1'b1, i[2:0]};
        end
        return res;
    endfunction

    logic [3:0] nxt;
    assign nxt = next_bit(mask_q, ch);

    assign {z, x, y} = ch;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ch     <= 3'd0;
            cnt    <= '0;
            reload <= '0;
            mask_q <= 8'd0;
            loop_q <= 1'b0;
            en     <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if (mask != 8'd0) begin
                            // Counter holds remaining cycles minus one, so a dwell of 0 acts as 1.
                            mask_q <= mask;
                            loop_q <= loop_mode;
                            reload <= (dwell == '0) ? '0 : dwell - 1'b1;
                            cnt    <= (dwell == '0) ? '0 : dwell - 1'b1;
                            ch     <= lowest_bit(mask);
                            en     <= 1'b1;
                            busy   <= 1'b1;
                            state  <= ACTIVE;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ACTIVE: begin
                    if (stop) begin
                        en    <= 1'b0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (cnt == '0) begin
                        if (nxt[3]) begin
                            ch  <= nxt[2:0];
                            cnt <= reload;
                        end else if (loop_q) begin
                            ch  <= lowest_bit(mask_q);
                            cnt <= reload;
                        end else begin
                            en    <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dcdr_scan_ctrl.sv
// Directed bench for dcdr_scan_ctrl: per-cycle vector table plus hand-written full-pass,
// long-dwell and decoder one-hot sequences.
module tb_dcdr_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst, start, stop, loop_mode;
    logic [7:0] mask;
    logic [3:0] dwell;
    logic       x, y, z, en, busy, done;

    int tests = 0;
    int fails = 0;

    dcdr_scan_ctrl #(.DWELL_W(4)) dut (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .mask(mask),
        .dwell(dwell), .loop_mode(loop_mode),
        .x(x), .y(y), .z(z), .en(en), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic       start;
        logic       stop;
        logic [7:0] mask;
        logic [3:0] dwell;
        logic       lp;
        logic [2:0] e_ch;
        logic       e_en;
        logic       e_busy;
        logic       e_done;
    } vec_t;

    vec_t vecs[$];

    // Expected outputs packed as {ch(z,x,y), en, busy, done}.
    task automatic check(input string name, input logic [5:0] act, input logic [5:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got ch/en/busy/done=%b, required %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic s, input logic p, input logic [7:0] m,
                         input logic [3:0] d, input logic l);
        rst = r; start = s; stop = p; mask = m; dwell = d; loop_mode = l;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] outs();
        return {z, x, y, en, busy, done};
    endfunction

    function automatic vec_t mk(logic r, logic s, logic p, logic [7:0] m, logic [3:0] d,
                                logic l, logic [2:0] c, logic e, logic b, logic dn);
        vec_t v;
        v.rst = r; v.start = s; v.stop = p; v.mask = m; v.dwell = d; v.lp = l;
        v.e_ch = c; v.e_en = e; v.e_busy = b; v.e_done = dn;
        return v;
    endfunction

    initial begin
        // Sparse mask, zero dwell: channels 2,5,7 one cycle each, then done.
        vecs.push_back(mk(0, 1, 0, 8'hA4, 4'd0, 0, 3'd2, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd5, 1, 3'd5, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd5, 1, 3'd7, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'd0, 0, 3'd7, 0, 0, 1));
        // Empty-mask start on the done cycle, then start/stop collision.
        vecs.push_back(mk(0, 1, 0, 8'h00, 4'd0, 0, 3'd7, 0, 0, 1));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'd0, 0, 3'd7, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 8'hFF, 4'd2, 0, 3'd7, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd2, 0, 3'd7, 0, 0, 0));
        // Loop 0,1,0,1 with start held, then stop on channel 1.
        vecs.push_back(mk(0, 1, 0, 8'h03, 4'd1, 1, 3'd0, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 4'd4, 0, 3'd1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'h00, 4'd4, 0, 3'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'd4, 0, 3'd1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h00, 4'd4, 0, 3'd1, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'h00, 4'd4, 0, 3'd1, 0, 0, 0));
        // Operand isolation: mask 0x12, dwell 2; inputs change mid-scan.
        vecs.push_back(mk(0, 1, 0, 8'h12, 4'd2, 0, 3'd1, 1, 1, 0));
        vecs.push_back(mk(0, 1, 0, 8'hFF, 4'd7, 1, 3'd1, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd7, 1, 3'd4, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd7, 1, 3'd4, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd7, 1, 3'd4, 0, 0, 1));
        // Reset mid-scan: mask FF dwell 3, reset while on channel 1.
        vecs.push_back(mk(0, 1, 0, 8'hFF, 4'd3, 0, 3'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd3, 0, 3'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd3, 0, 3'd0, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd3, 0, 3'd1, 1, 1, 0));
        vecs.push_back(mk(1, 0, 0, 8'hFF, 4'd3, 0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd3, 0, 3'd0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 8'hFF, 4'd3, 0, 3'd0, 0, 0, 0));
        // Single-bit mask in loop mode holds channel 6 with en steady.
        vecs.push_back(mk(0, 1, 0, 8'h40, 4'd1, 1, 3'd6, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h40, 4'd1, 1, 3'd6, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h40, 4'd1, 1, 3'd6, 1, 1, 0));
        vecs.push_back(mk(0, 0, 0, 8'h40, 4'd1, 1, 3'd6, 1, 1, 0));
        vecs.push_back(mk(0, 0, 1, 8'h40, 4'd1, 1, 3'd6, 0, 0, 0));

        // Reset state.
        drive(1, 0, 0, 8'h00, 4'd0, 0);
        drive(1, 0, 0, 8'h00, 4'd0, 0);
        check("reset_state", outs(), 6'b000_000);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].start, vecs[i].stop, vecs[i].mask, vecs[i].dwell, vecs[i].lp);
            check($sformatf("vec%0d", i), outs(),
                  {vecs[i].e_ch, vecs[i].e_en, vecs[i].e_busy, vecs[i].e_done});
        end

        // Full single pass, mask FF, dwell 2: 16 busy cycles, done on cycle 17.
        drive(0, 1, 0, 8'hFF, 4'd2, 0);
        for (int i = 0; i < 16; i++) begin
            logic [2:0] c;
            logic [7:0] dec_exp, dec_act;
            c = 3'(i / 2);
            check($sformatf("full_pass_c%0d", i), outs(), {c, 3'b110});
            dec_exp = 8'd1 << c;
            dec_act = en ? (8'd1 << {z, x, y}) : 8'd0;
            tests++;
            if (dec_act !== dec_exp) begin
                fails++;
                $display("FAIL decoder_onehot_c%0d: got %b, required %b", i, dec_act, dec_exp);
            end
            drive(0, 0, 0, 8'h00, 4'd0, 0);
        end
        check("full_pass_done", outs(), {3'd7, 3'b001});
        drive(0, 0, 0, 8'h00, 4'd0, 0);
        check("full_pass_done_clear", outs(), {3'd7, 3'b000});

        // Maximum dwell (15) on channel 0, single pass; busy must last exactly 15 cycles.
        begin
            int busy_cycles;
            int waited;
            busy_cycles = 0;
            waited = 0;
            drive(0, 1, 0, 8'h01, 4'd15, 0);
            while (busy && waited < 40) begin
                busy_cycles++;
                waited++;
                drive(0, 0, 0, 8'h00, 4'd0, 0);
            end
            tests++;
            if (busy_cycles != 15) begin
                fails++;
                $display("FAIL max_dwell_len: got %0d busy cycles, required 15", busy_cycles);
            end
            check("max_dwell_done", outs(), {3'd0, 3'b001});
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
